// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//   Bit-serial magnitude comparator. Two WIDTH-bit operands are captured on a
//   start strobe and scanned MSB-first, one bit per clock. Exactly one of
//   lt/eq/gt is reported, together with a one-cycle done pulse.
//
// Parameters
//   WIDTH       operand width in bits (WIDTH >= 2)
//   EARLY_EXIT  1: finish at the first differing bit, 0: always scan all bits
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request; a/b sampled on the same edge
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   busy   out  1      high while a compare is scanning
//   done   out  1      one-cycle pulse, result valid
//   lt     out  1      A < B
//   eq     out  1      A == B
//   gt     out  1      A > B
//
// Configuration
//   SIGNED_CMP_EN  when defined, operands are two's complement: the sense of
//                  the sign bit is inverted, lower bits compare as unsigned.

module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam bit EARLY = (EARLY_EXIT != 0);
`ifdef SIGNED_CMP_EN
  localparam bit SIGNED_CMP = 1'b1;
`else
  localparam bit SIGNED_CMP = 1'b0;
`endif
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, a_next;
  logic [WIDTH-1:0] b_q, b_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             found, found_next;
  logic             rec_gt, rec_gt_next;
  logic             lt_next, eq_next, gt_next;

  logic bit_a, bit_b, cur_diff, cur_gt, accept;

  assign bit_a    = a_q[idx];
  assign bit_b    = b_q[idx];
  assign cur_diff = bit_a ^ bit_b;
  // The sign bit of a two's complement value carries negative weight, so a
  // set sign bit means the smaller operand.
  assign cur_gt   = (SIGNED_CMP && (idx == MSB_IDX)) ? (~bit_a & bit_b)
                                                     : (bit_a & ~bit_b);
  assign accept   = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == COMPARE);
  assign done = (state == DONE);

  // Registers every piece of state; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      found  <= 1'b0;
      rec_gt <= 1'b0;
      lt     <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
    end else begin
      state  <= state_next;
      a_q    <= a_next;
      b_q    <= b_next;
      idx    <= idx_next;
      found  <= found_next;
      rec_gt <= rec_gt_next;
      lt     <= lt_next;
      eq     <= eq_next;
      gt     <= gt_next;
    end
  end

  // Next-state logic. The first differing bit is recorded in found/rec_gt and
  // never overwritten; the visible result is published only on entry to DONE
  // so lt/eq/gt stay all-zero while a compare is still scanning.
  always_comb begin
    state_next  = state;
    a_next      = a_q;
    b_next      = b_q;
    idx_next    = idx;
    found_next  = found;
    rec_gt_next = rec_gt;
    lt_next     = lt;
    eq_next     = eq;
    gt_next     = gt;

    if (accept) begin
      state_next  = COMPARE;
      a_next      = a;
      b_next      = b;
      idx_next    = MSB_IDX;
      found_next  = 1'b0;
      rec_gt_next = 1'b0;
      lt_next     = 1'b0;
      eq_next     = 1'b0;
      gt_next     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        COMPARE: begin
          if (!found && cur_diff) begin
            found_next  = 1'b1;
            rec_gt_next = cur_gt;
          end
          if ((EARLY && !found && cur_diff) || (idx == '0)) begin
            state_next = DONE;
            lt_next    = found_next & ~rec_gt_next;
            gt_next    = found_next & rec_gt_next;
            eq_next    = ~found_next;
          end else begin
            idx_next = idx - 1'b1;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator
//   Self-checking bench for serial_mag_comparator. Three instances share the
//   clock and reset: WIDTH=8 with early exit, WIDTH=8 scanning all bits, and
//   WIDTH=2 with early exit. Expected results and latencies come from a plain
//   integer model of the compare. Honours SIGNED_CMP_EN when defined.

`timescale 1ns/1ps

module tb_serial_mag_comparator;

  logic       clk;
  logic       rst_n;
  logic       start_v [3];
  logic [7:0] a_v     [3];
  logic [7:0] b_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       lt_v    [3];
  logic       eq_v    [3];
  logic       gt_v    [3];

  int tests_run;
  int tests_failed;

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1)) dut_early (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .gt(gt_v[0])
  );

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .gt(gt_v[1])
  );

  serial_mag_comparator #(.WIDTH(2), .EARLY_EXIT(1)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][1:0]), .b(b_v[2][1:0]),
    .busy(busy_v[2]), .done(done_v[2]), .lt(lt_v[2]), .eq(eq_v[2]), .gt(gt_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int widthOf(input int sel);
    return (sel == 2) ? 2 : 8;
  endfunction

  function automatic logic [2:0] resOf(input int sel);
    return {lt_v[sel], eq_v[sel], gt_v[sel]};
  endfunction

  // Reference compare on integer values: {lt, eq, gt}.
  function automatic logic [2:0] refResult(input int w, input logic [7:0] av, input logic [7:0] bv);
    int sa, sb;
    sa = int'(av) & ((1 << w) - 1);
    sb = int'(bv) & ((1 << w) - 1);
`ifdef SIGNED_CMP_EN
    if (sa >= (1 << (w - 1))) sa -= (1 << w);
    if (sb >= (1 << (w - 1))) sb -= (1 << w);
`endif
    if (sa < sb) return 3'b100;
    if (sa == sb) return 3'b010;
    return 3'b001;
  endfunction

  // Cycles from the capture edge to the edge after which done is high.
  function automatic int refLatency(input int w, input bit ee, input logic [7:0] av, input logic [7:0] bv);
    int x, msb;
    x = (int'(av) ^ int'(bv)) & ((1 << w) - 1);
    if (!ee || x == 0) return w;
    msb = 0;
    for (int i = 0; i < w; i++) if (x[i]) msb = i;
    return w - msb;
  endfunction

  // Drives a start request at the current (post-edge) time and returns just
  // after the capture edge with fresh garbage on a/b.
  task automatic applyStimulus(input int sel, input logic [7:0] av, input logic [7:0] bv);
    start_v[sel] = 1'b1;
    a_v[sel] = av;
    b_v[sel] = bv;
    @(posedge clk);
    #1;
    start_v[sel] = 1'b0;
    a_v[sel] = 8'($urandom);
    b_v[sel] = 8'($urandom);
  endtask

  // Follows one operation from just after its capture edge to its done pulse.
  // poke>0 raises a conflicting start at that cycle; chain starts (ca, cb) in
  // the DONE cycle.
  task automatic checkRun(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input int poke, input bit chain,
                          input logic [7:0] ca, input logic [7:0] cb);
    int w, k, cycles, busy_cnt;
    bit seen;
    logic [2:0] exp_res;
    w = widthOf(sel);
    k = refLatency(w, sel != 1, av, bv);
    exp_res = refResult(w, av, bv);
    cycles = 0;
    seen = 1'b0;
    busy_cnt = busy_v[sel] ? 1 : 0;
    checkOutput("result_cleared", 32'(resOf(sel)), 32'd0);
    while (!seen && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      start_v[sel] = 1'b0;
      if (done_v[sel]) begin
        seen = 1'b1;
      end else begin
        if (busy_v[sel]) busy_cnt++;
        if (cycles == poke) begin
          start_v[sel] = 1'b1;
          a_v[sel] = 8'hFF;
          b_v[sel] = 8'h00;
        end
      end
    end
    if (!seen) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency", 32'(cycles), 32'(k));
    checkOutput("busy_cycles", 32'(busy_cnt), 32'(k));
    checkOutput("busy_at_done", 32'(busy_v[sel]), 32'd0);
    checkOutput("result", 32'(resOf(sel)), 32'(exp_res));
    if (chain) begin
      applyStimulus(sel, ca, cb);
    end else begin
      @(posedge clk);
      #1;
      checkOutput("done_pulse_end", 32'(done_v[sel]), 32'd0);
      checkOutput("result_held", 32'(resOf(sel)), 32'(exp_res));
    end
  endtask

  task automatic runOp(input int sel, input logic [7:0] av, input logic [7:0] bv);
    applyStimulus(sel, av, bv);
    checkRun(sel, av, bv, 0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int done_seen, busy_seen;
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      a_v[i] = 8'h00;
      b_v[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      checkOutput("reset_outputs", 32'({busy_v[i], done_v[i], resOf(i)}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    runOp(0, 8'h80, 8'h7F);
    runOp(0, 8'h5A, 8'h5A);
    runOp(0, 8'h12, 8'h13);
    runOp(1, 8'h80, 8'h00);
    runOp(1, 8'h12, 8'h13);
    runOp(1, 8'h7F, 8'h7F);

    // Conflicting start while busy is ignored; start in DONE runs back-to-back.
    applyStimulus(0, 8'h12, 8'h13);
    checkRun(0, 8'h12, 8'h13, 2, 1'b1, 8'h40, 8'hC0);
    checkRun(0, 8'h40, 8'hC0, 0, 1'b0, 8'h00, 8'h00);

    // Randomized operations on both WIDTH=8 variants.
    for (int n = 0; n < 60; n++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'd1 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      runOp(n % 2, ra, rb);
    end

    // All sixteen operand pairs at WIDTH=2.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        runOp(2, 8'(i), 8'(j));

    // Reset in the middle of an operation.
    applyStimulus(0, 8'h5A, 8'h5A);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_abort", 32'({busy_v[0], done_v[0], resOf(0)}), 32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_v[0]) done_seen++;
      if (busy_v[0]) busy_seen++;
    end
    checkOutput("no_done_after_abort", 32'(done_seen), 32'd0);
    checkOutput("no_busy_after_abort", 32'(busy_seen), 32'd0);
    runOp(0, 8'h01, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
